// File: rtl/xbar_cfg_pkg.sv
// Shared types and default sizing for the crossbar select loader and the crossbar it feeds.
package xbar_cfg_pkg;

   localparam int DEF_NUM_IN  = 31;
   localparam int DEF_NUM_OUT = 40;
   localparam int DEF_SEL_W   = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } cfg_state_t;

   function automatic int idx_width(input int num_out);
      return (num_out > 1) ? $clog2(num_out) : 1;
   endfunction

endpackage

// File: rtl/xbar_cfg_bank.sv
// Shadow select bank written one slot per beat, plus the active bank loaded from it in one
// cycle so the crossbar only ever sees a complete select vector.
module xbar_cfg_bank
   import xbar_cfg_pkg::*;
#(
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int SEL_W   = DEF_SEL_W,
   parameter int IDX_W   = idx_width(DEF_NUM_OUT)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_wr_en,
   input  logic [IDX_W-1:0]         i_wr_idx,
   input  logic [SEL_W-1:0]         i_wr_data,
   input  logic                     i_commit,
   output logic [NUM_OUT*SEL_W-1:0] o_active
);

   logic [NUM_OUT*SEL_W-1:0] r_shadow;
   logic [NUM_OUT*SEL_W-1:0] r_active;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
         r_active <= '0;
      end else begin
         if (i_wr_en)
            r_shadow[32'(i_wr_idx) * SEL_W +: SEL_W] <= i_wr_data;
         if (i_commit)
            r_active <= r_shadow;
      end
   end

   assign o_active = r_active;

endmodule

// File: rtl/xbar_cfg_loader.sv
// Writer side of the crossbar select interface: streams NUM_OUT selects into a shadow bank
// and commits them atomically. Define XBAR_CFG_RANGE_CHECK_EN to reject loads with selects >= NUM_IN.
module xbar_cfg_loader
   import xbar_cfg_pkg::*;
#(
   parameter int NUM_IN  = DEF_NUM_IN,
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int SEL_W   = DEF_SEL_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     io_cfg_start,
   input  logic                     io_cfg_valid,
   output logic                     io_cfg_ready,
   input  logic [SEL_W-1:0]         io_cfg_data,
   output logic                     io_cfg_busy,
   output logic                     io_cfg_done,
   output logic                     io_cfg_err,
   output logic [NUM_OUT*SEL_W-1:0] io_mux_configs
);

   localparam int               IDX_W    = idx_width(NUM_OUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

   if ((1 << SEL_W) < NUM_IN) begin : g_sel_w_too_narrow
      $error("SEL_W cannot encode every crossbar input");
   end

   cfg_state_t       r_state;
   logic [IDX_W-1:0] r_idx;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             w_beat;
   logic             w_commit;

   // A start in LOAD wins over a beat presented in the same cycle.
   assign w_beat   = r_ready && io_cfg_valid && !io_cfg_start;
   assign w_commit = (r_state == COMMIT);

`ifdef XBAR_CFG_RANGE_CHECK_EN
   logic r_err;
   logic w_bad;
   assign w_bad      = w_beat && (32'(io_cfg_data) >= 32'(NUM_IN));
   assign io_cfg_err = r_err;
`else
   assign io_cfg_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef XBAR_CFG_RANGE_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (io_cfg_start) begin
                  r_state <= LOAD;
                  r_idx   <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
`ifdef XBAR_CFG_RANGE_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (io_cfg_start) begin
                  r_idx <= '0;
`ifdef XBAR_CFG_RANGE_CHECK_EN
                  r_err <= 1'b0;
`endif
               end else if (w_beat) begin
`ifdef XBAR_CFG_RANGE_CHECK_EN
                  if (w_bad)
                     r_err <= 1'b1;
`endif
                  if (r_idx == LAST_IDX) begin
                     r_ready <= 1'b0;
`ifdef XBAR_CFG_RANGE_CHECK_EN
                     // A bad select anywhere in the sequence abandons the commit.
                     if (r_err || w_bad) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= COMMIT;
                     end
`else
                     r_state <= COMMIT;
`endif
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            COMMIT: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   xbar_cfg_bank #(
      .NUM_OUT (NUM_OUT),
      .SEL_W   (SEL_W),
      .IDX_W   (IDX_W)
   ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_beat),
      .i_wr_idx  (r_idx),
      .i_wr_data (io_cfg_data),
      .i_commit  (w_commit),
      .o_active  (io_mux_configs)
   );

   assign io_cfg_ready = r_ready;
   assign io_cfg_busy  = r_busy;
   assign io_cfg_done  = r_done;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Scoreboard bench for xbar_cfg_loader: expected select vectors are queued when a load is
// driven and compared against io_mux_configs on each done pulse.
module tb_xbar_cfg_loader;

   localparam int NUM_IN  = 31;
   localparam int NUM_OUT = 40;
   localparam int SEL_W   = 5;
   localparam int CW      = NUM_OUT * SEL_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          valid;
   logic [SEL_W-1:0] data;
   logic          ready;
   logic          busy;
   logic          done;
   logic          err;
   logic [CW-1:0] cfg;

   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] sb[$];
   logic [CW-1:0] cur_active;

   always #5 clk = ~clk;

   xbar_cfg_loader #(
      .NUM_IN  (NUM_IN),
      .NUM_OUT (NUM_OUT),
      .SEL_W   (SEL_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .io_cfg_start   (start),
      .io_cfg_valid   (valid),
      .io_cfg_ready   (ready),
      .io_cfg_data    (data),
      .io_cfg_busy    (busy),
      .io_cfg_done    (done),
      .io_cfg_err     (err),
      .io_mux_configs (cfg)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [SEL_W-1:0] d);
      int n = 0;
      valid = 1'b1;
      data  = d;
      while (!ready && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL beat_ready: ready=%0b required 1", ready);
      end
      step();
      valid = 1'b0;
   endtask

   task automatic wait_commit(input logic [CW-1:0] prev, output int lat);
      logic [CW-1:0] exp;
      lat = 0;
      while (done !== 1'b1 && lat < 8) begin
         checks++;
         if (cfg !== prev) begin
            errors++;
            $display("FAIL cfg_stable: cfg=%h required %h", cfg, prev);
         end
         step();
         lat++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%0b required 1", done);
      end else if (sb.size() == 0) begin
         errors++;
         $display("FAIL sb_empty: done seen with no expected config queued");
      end else begin
         exp = sb.pop_front();
         checks++;
         if (cfg !== exp) begin
            errors++;
            $display("FAIL commit_cfg: cfg=%h required %h", cfg, exp);
         end
         cur_active = exp;
         step();
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%0b required 0", done);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_commit: busy=%0b required 0", busy);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      data  = '0;
      cur_active = '0;
      step();
      step();
      checks++;
      if (cfg !== '0) begin errors++; $display("FAIL reset_cfg: cfg=%h required 0", cfg); end
      checks++;
      if ({ready, busy, done, err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: ready/busy/done/err=%b required 0000", {ready, busy, done, err});
      end
      reset = 1'b0;
      step();
      checks++;
      if ({ready, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_ctrl: ready/busy/done=%b required 000", {ready, busy, done});
      end
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] exp;
      int lat;
      for (int k = 0; k < NUM_OUT; k++) exp[k*SEL_W +: SEL_W] = SEL_W'(k % NUM_IN);
      sb.push_back(exp);
      pulse_start();
      checks++;
      if ({ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL load_entry: ready/busy=%b required 11", {ready, busy});
      end
      for (int k = 0; k < NUM_OUT; k++) send_beat(SEL_W'(k % NUM_IN));
      checks++;
      if ({ready, busy, done} !== 3'b010) begin
         errors++;
         $display("FAIL commit_state: ready/busy/done=%b required 010", {ready, busy, done});
      end
      wait_commit(cur_active, lat);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL commit_latency: lat=%0d required 1", lat); end
   endtask

   task automatic test_random_gaps();
      logic [CW-1:0] exp;
      logic [CW-1:0] prev;
      int lat;
      prev = cur_active;
      valid = 1'b1;
      data  = 5'h1f;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ready !== 1'b0 || cfg !== prev) begin
            errors++;
            $display("FAIL idle_beat: ready=%0b cfg=%h required 0 %h", ready, cfg, prev);
         end
      end
      valid = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) exp[k*SEL_W +: SEL_W] = SEL_W'((k * 7 + 3) % NUM_IN);
      sb.push_back(exp);
      pulse_start();
      for (int k = 0; k < NUM_OUT; k++) begin
         int gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) step();
         send_beat(SEL_W'((k * 7 + 3) % NUM_IN));
         checks++;
         if (cfg !== prev) begin
            errors++;
            $display("FAIL gap_stable: cfg=%h required %h", cfg, prev);
         end
      end
      valid = 1'b1;
      data  = 5'h1e;
      wait_commit(prev, lat);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ready !== 1'b0 || busy !== 1'b0 || cfg !== exp) begin
            errors++;
            $display("FAIL post_idle: ready=%0b busy=%0b cfg=%h required 0 0 %h", ready, busy, cfg, exp);
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_restart();
      logic [CW-1:0] exp;
      logic [CW-1:0] prev;
      int lat;
      prev = cur_active;
      pulse_start();
      for (int k = 0; k < 20; k++) send_beat(5'd7);
      checks++;
      if (cfg !== prev) begin errors++; $display("FAIL partial_held: cfg=%h required %h", cfg, prev); end
      start = 1'b1;
      valid = 1'b1;
      data  = 5'd9;
      step();
      start = 1'b0;
      valid = 1'b0;
      checks++;
      if ({ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL restart_state: ready/busy=%b required 11", {ready, busy});
      end
      for (int k = 0; k < NUM_OUT; k++) exp[k*SEL_W +: SEL_W] = 5'd3;
      sb.push_back(exp);
      for (int k = 0; k < NUM_OUT - 1; k++) send_beat(5'd3);
      checks++;
      if ({ready, busy, done} !== 3'b110) begin
         errors++;
         $display("FAIL restart_count: ready/busy/done=%b required 110", {ready, busy, done});
      end
      send_beat(5'd3);
      wait_commit(prev, lat);
   endtask

   task automatic test_range();
      logic [CW-1:0] exp;
      logic [CW-1:0] prev;
      int lat;
      prev = cur_active;
`ifdef XBAR_CFG_RANGE_CHECK_EN
      pulse_start();
      for (int k = 0; k < NUM_OUT; k++) begin
         send_beat((k == 10) ? 5'd31 : SEL_W'(k % NUM_IN));
         if (k == 9 || k == 10) begin
            checks++;
            if (err !== (k == 10)) begin
               errors++;
               $display("FAIL err_beat%0d: err=%0b required %0b", k, err, (k == 10));
            end
         end
      end
      checks++;
      if ({ready, busy, err} !== 3'b001) begin
         errors++;
         $display("FAIL abort_state: ready/busy/err=%b required 001", {ready, busy, err});
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (done !== 1'b0 || cfg !== prev || err !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: done=%0b err=%0b cfg=%h required 0 1 %h", done, err, cfg, prev);
         end
         step();
      end
      pulse_start();
      checks++;
      if ({err, busy} !== 2'b01) begin
         errors++;
         $display("FAIL err_clear: err/busy=%b required 01", {err, busy});
      end
      for (int k = 0; k < NUM_OUT; k++) exp[k*SEL_W +: SEL_W] = SEL_W'((k + 1) % NUM_IN);
      sb.push_back(exp);
      for (int k = 0; k < NUM_OUT; k++) send_beat(SEL_W'((k + 1) % NUM_IN));
      wait_commit(prev, lat);
`else
      for (int k = 0; k < NUM_OUT; k++) exp[k*SEL_W +: SEL_W] = (k == 10) ? 5'd31 : SEL_W'(k % NUM_IN);
      sb.push_back(exp);
      pulse_start();
      for (int k = 0; k < NUM_OUT; k++) send_beat((k == 10) ? 5'd31 : SEL_W'(k % NUM_IN));
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_tied: err=%0b required 0", err); end
      wait_commit(prev, lat);
`endif
   endtask

   task automatic test_reset_midload();
      logic [CW-1:0] exp;
      int lat;
      pulse_start();
      for (int k = 0; k < 26; k++) send_beat(SEL_W'((k + 5) % NUM_IN));
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (cfg !== '0) begin errors++; $display("FAIL async_cfg: cfg=%h required 0", cfg); end
      checks++;
      if ({ready, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL async_ctrl: ready/busy/done=%b required 000", {ready, busy, done});
      end
      @(negedge clk);
      reset = 1'b0;
      cur_active = '0;
      step();
      checks++;
      if (cfg !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: cfg=%h busy=%0b required 0 0", cfg, busy);
      end
      for (int k = 0; k < NUM_OUT; k++) exp[k*SEL_W +: SEL_W] = SEL_W'((39 - k) % NUM_IN);
      sb.push_back(exp);
      pulse_start();
      for (int k = 0; k < NUM_OUT; k++) send_beat(SEL_W'((39 - k) % NUM_IN));
      wait_commit('0, lat);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: size=%0d required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_random_gaps();
      test_restart();
      test_range();
      test_reset_midload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
